// File: rtl/qubit_swap_stage.sv
// qubit_swap_stage
//   Elastic single-register pipeline stage. It applies SWAP or controlled SWAP
//   (Fredkin) between two runtime-selected qubits of an N-qubit state vector.
//   The operation is a pure permutation of amplitude slots. Each output slot i
//   takes the input slot j that the selected gate maps onto it.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_r, in_i          : packed input amplitudes, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid / in_ready : upstream handshake (in_ready = !out_valid || out_ready)
//   cfg_qa, cfg_qb      : qubit pair to exchange
//   cfg_qc              : control qubit (controlled mode only)
//   cfg_mode            : 0 bypass, 1 SWAP, 2 controlled SWAP, 3 bypass
//   out_r, out_i        : registered permuted amplitudes
//   out_valid/out_ready : downstream handshake
//   cfg_err             : registered alongside the data; the config for that
//                         vector was invalid and the data passed as identity

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

// qubit_swap_lane
//   Source-index select for one output amplitude slot (LANE). The lane's own
//   index is a constant, so the bit picks and bit rewrites reduce to small
//   compare-and-select logic.
//   do_swap      : exchange is enabled (valid config, SWAP or controlled mode)
//   ctrl         : controlled mode, exchange only when bit qc of LANE is 1
//   qa, qb, qc   : qubit indices
//   vec_r, vec_i : whole input vector
//   lane_r/lane_i: selected amplitude for this slot
module qubit_swap_lane #(
  parameter int N_QUBITS   = 3,
  parameter int IDX_W      = 2,
  parameter int DATA_WIDTH = 16,
  parameter int LANE       = 0
) (
  input  logic                                        do_swap,
  input  logic                                        ctrl,
  input  logic [IDX_W-1:0]                            qa,
  input  logic [IDX_W-1:0]                            qb,
  input  logic [IDX_W-1:0]                            qc,
  input  logic [(1<<N_QUBITS)-1:0][DATA_WIDTH-1:0]    vec_r,
  input  logic [(1<<N_QUBITS)-1:0][DATA_WIDTH-1:0]    vec_i,
  output logic [DATA_WIDTH-1:0]                       lane_r,
  output logic [DATA_WIDTH-1:0]                       lane_i
);
  localparam logic [N_QUBITS-1:0] IDX = N_QUBITS'(LANE);

  logic                bit_a, bit_b, bit_c;
  logic [N_QUBITS-1:0] src;

  // Match-against-constant loops avoid variable bit selects. An index
  // outside the vector simply matches nothing; the top level has already
  // turned such configs into identity.
  always_comb begin
    bit_a = 1'b0;
    bit_b = 1'b0;
    bit_c = 1'b0;
    for (int b = 0; b < N_QUBITS; b++) begin
      if (qa == IDX_W'(b)) bit_a = IDX[b];
      if (qb == IDX_W'(b)) bit_b = IDX[b];
      if (qc == IDX_W'(b)) bit_c = IDX[b];
    end
    src = IDX;
    if (do_swap && (!ctrl || bit_c)) begin
      // qa == qb writes the same bit with its own value, which is identity
      for (int b = 0; b < N_QUBITS; b++) begin
        if (qa == IDX_W'(b)) src[b] = bit_b;
        if (qb == IDX_W'(b)) src[b] = bit_a;
      end
    end
  end

  assign lane_r = vec_r[src];
  assign lane_i = vec_i[src];
endmodule

module qubit_swap_stage #(
  parameter int N_QUBITS   = 3,
  parameter int DATA_WIDTH = `TOTAL_WIDTH,
  parameter int IDX_W      = (N_QUBITS <= 2) ? 1 : $clog2(N_QUBITS)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [(1<<N_QUBITS)*DATA_WIDTH-1:0]     in_r,
  input  logic [(1<<N_QUBITS)*DATA_WIDTH-1:0]     in_i,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [IDX_W-1:0]                        cfg_qa,
  input  logic [IDX_W-1:0]                        cfg_qb,
  input  logic [IDX_W-1:0]                        cfg_qc,
  input  logic [1:0]                              cfg_mode,
  output logic [(1<<N_QUBITS)*DATA_WIDTH-1:0]     out_r,
  output logic [(1<<N_QUBITS)*DATA_WIDTH-1:0]     out_i,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    cfg_err
);
  localparam int NUM_LANES = 1 << N_QUBITS;
  localparam int STAGES    = 1;

  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] vec_t;

  vec_t vin_r, vin_i, perm_r, perm_i, q_r, q_i;
  logic q_err;
  logic [STAGES:0] vld_pipe;  // [0] accepted this cycle, [1] output register full

  assign vin_r = in_r;
  assign vin_i = in_i;

  // ---------------------------------------------------------------- config
  logic mode_swap, mode_cswap, bad_pair, bad_ctrl, err, do_swap;

  function automatic logic idx_bad(input logic [IDX_W-1:0] q);
    return int'(q) >= N_QUBITS;
  endfunction

  assign mode_swap  = (cfg_mode == 2'd1);
  assign mode_cswap = (cfg_mode == 2'd2);
  assign bad_pair   = idx_bad(cfg_qa) || idx_bad(cfg_qb);
  assign bad_ctrl   = idx_bad(cfg_qc) || (cfg_qc == cfg_qa) || (cfg_qc == cfg_qb);

  // Bypass and the reserved mode never flag an error: they use no indices.
  always_comb begin
    err = 1'b0;
    if (mode_swap)  err = bad_pair;
    if (mode_cswap) err = bad_pair || bad_ctrl;
  end

  // An invalid config falls back to identity.
  assign do_swap = (mode_swap || mode_cswap) && !err;

  // ----------------------------------------------------------- permutation
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    qubit_swap_lane #(
      .N_QUBITS  (N_QUBITS),
      .IDX_W     (IDX_W),
      .DATA_WIDTH(DATA_WIDTH),
      .LANE      (l)
    ) u_lane (
      .do_swap(do_swap),
      .ctrl   (mode_cswap),
      .qa     (cfg_qa),
      .qb     (cfg_qb),
      .qc     (cfg_qc),
      .vec_r  (vin_r),
      .vec_i  (vin_i),
      .lane_r (perm_r[l]),
      .lane_i (perm_i[l])
    );
  end

  // ------------------------------------------------------------- handshake
  // The output register may load whenever it is empty or being drained this
  // same cycle. That gives full throughput with a single register, at the
  // cost of a combinational out_ready -> in_ready path.
  assign in_ready    = !vld_pipe[1] || out_ready;
  assign vld_pipe[0] = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      q_r         <= '0;
      q_i         <= '0;
      q_err       <= 1'b0;
    end else if (vld_pipe[0]) begin
      vld_pipe[1] <= 1'b1;
      q_r         <= perm_r;
      q_i         <= perm_i;
      q_err       <= err;
    end else if (out_ready) begin
      vld_pipe[1] <= 1'b0;  // drained with nothing behind it; data may stay
    end
  end

  assign out_r     = q_r;
  assign out_i     = q_i;
  assign cfg_err   = q_err;
  assign out_valid = vld_pipe[1];
endmodule
